// File: rtl/br_resolve.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : br_resolve
// Purpose  : EX-stage branch resolution and 2-bit saturating-counter direction
//            predictor for an RV32I pipeline. ID reads the branch history
//            table (BHT) combinationally and EX trains it. A conditional
//            branch that mispredicts, and every JALR, raises a one-cycle
//            registered redirect/flush carrying the corrected next PC.
// Ports    :
//   clk                  rising-edge clock
//   rst_n                asynchronous active-low reset
//   id_pc_i       [31:0] PC of the instruction in ID (BHT lookup)
//   id_pred_taken_o      predicted direction for id_pc_i (combinational)
//   ex_valid_i           EX holds a real instruction
//   ex_stall_i           EX held this cycle; same instruction next cycle
//   ex_is_br_i           EX instruction is a conditional branch
//   ex_is_jalr_i         EX instruction is a JALR
//   ex_pc_i       [31:0] PC of the EX instruction
//   ex_pred_taken_i      direction predicted in ID for the EX instruction
//   br_en_i              comparator result for the EX branch
//   ex_br_target_i[31:0] pc + imm_b
//   ex_jalr_target_i[31:0] (rs1 + imm_i) & ~1
//   redirect_o           registered; fetch must load redirect_pc_o
//   redirect_pc_o [31:0] registered corrected next PC (held between redirects)
//   flush_o              registered; squash IF/ID and ID/EX (same as redirect)
//   br_count_o    [31:0] number of resolved conditional branches
//   mispred_count_o[31:0] number of mispredicted conditional branches
// Revision : 1.0 - initial release
// ============================================================================
module br_resolve #(
    parameter int         BHT_IDX_W = 6,
    parameter logic [1:0] CTR_INIT  = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] id_pc_i,
    output logic        id_pred_taken_o,
    input  logic        ex_valid_i,
    input  logic        ex_stall_i,
    input  logic        ex_is_br_i,
    input  logic        ex_is_jalr_i,
    input  logic [31:0] ex_pc_i,
    input  logic        ex_pred_taken_i,
    input  logic        br_en_i,
    input  logic [31:0] ex_br_target_i,
    input  logic [31:0] ex_jalr_target_i,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        flush_o,
    output logic [31:0] br_count_o,
    output logic [31:0] mispred_count_o
);

    localparam int BHT_ENTRIES = 1 << BHT_IDX_W;

    // RUN: EX is on the correct path. SHADOW: the cycle right after a
    // redirect-causing resolve, when EX holds a wrong-path instruction.
    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_SHADOW = 1'b1
    } state_t;

    state_t      state_q;
    logic [1:0]  bht_q [BHT_ENTRIES];
    logic        redirect_q;
    logic [31:0] redirect_pc_q;
    logic [31:0] br_count_q;
    logic [31:0] mispred_count_q;

    logic [BHT_IDX_W-1:0] w_id_idx;
    logic [BHT_IDX_W-1:0] w_ex_idx;
    logic                 w_res;
    logic                 w_jalr;
    logic                 w_br;
    logic                 w_mis;
    logic [1:0]           w_ctr_d;
    logic                 redirect_d;
    logic [31:0]          redirect_pc_d;
    logic                 w_unused;

    // Saturating 2-bit counter step: +1 on taken, -1 on not-taken.
    function automatic logic [1:0] f_ctr_next(input logic [1:0] ctr,
                                              input logic       taken);
        if (taken) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'd1;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'd1;
    endfunction

    assign w_id_idx = id_pc_i[BHT_IDX_W+1:2];
    assign w_ex_idx = ex_pc_i[BHT_IDX_W+1:2];

    // Only the index bits of the ID PC select an entry.
    assign w_unused = ^{id_pc_i[31:BHT_IDX_W+2], id_pc_i[1:0]};

    // Read before write: a same-entry update from EX becomes visible only
    // after the clock edge.
    assign id_pred_taken_o = bht_q[w_id_idx][1];

    // A stalled instruction is re-presented, so it resolves only in its
    // non-stalled cycle. Nothing resolves in the wrong-path shadow cycle.
    assign w_res  = ex_valid_i & ~ex_stall_i & (state_q == ST_RUN);
    // JALR takes priority if both decode flags are (illegally) set.
    assign w_jalr = w_res & ex_is_jalr_i;
    assign w_br   = w_res & ex_is_br_i & ~ex_is_jalr_i;
    assign w_mis  = br_en_i ^ ex_pred_taken_i;

    assign w_ctr_d = f_ctr_next(bht_q[w_ex_idx], br_en_i);

    always_comb begin
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        if (w_jalr) begin
            redirect_d    = 1'b1;
            redirect_pc_d = ex_jalr_target_i;
        end else if (w_br && w_mis) begin
            redirect_d    = 1'b1;
            // Fall-through PC wraps naturally in 32 bits.
            redirect_pc_d = br_en_i ? ex_br_target_i : ex_pc_i + 32'd4;
        end
    end

    // Branch history table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= CTR_INIT;
            end
        end else if (w_br) begin
            bht_q[w_ex_idx] <= w_ctr_d;
        end
    end

    // Control FSM with registered redirect and statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_RUN;
            redirect_q      <= 1'b0;
            redirect_pc_q   <= 32'd0;
            br_count_q      <= 32'd0;
            mispred_count_q <= 32'd0;
        end else begin
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            if (w_br) begin
                br_count_q      <= br_count_q + 32'd1;
                mispred_count_q <= mispred_count_q + {31'd0, w_mis};
            end
            case (state_q)
                ST_RUN: begin
                    if (redirect_d) begin
                        state_q <= ST_SHADOW;
                    end
                end
                ST_SHADOW: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign redirect_o      = redirect_q;
    assign flush_o         = redirect_q;
    assign redirect_pc_o   = redirect_pc_q;
    assign br_count_o      = br_count_q;
    assign mispred_count_o = mispred_count_q;

endmodule
`default_nettype wire

// File: tb/tb_br_resolve.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_br_resolve
// Purpose  : Self-checking bench for br_resolve. Expected redirects (cycle and
//            target) are queued when stimulus is issued; a monitor pops and
//            compares whenever the DUT raises redirect. Counters and BHT
//            predictions are checked against hand-computed constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_br_resolve;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] id_pc = 32'd0;
    logic        id_pred_taken;
    logic        ex_valid = 1'b0;
    logic        ex_stall = 1'b0;
    logic        ex_is_br = 1'b0;
    logic        ex_is_jalr = 1'b0;
    logic [31:0] ex_pc = 32'd0;
    logic        ex_pred_taken = 1'b0;
    logic        br_en = 1'b0;
    logic [31:0] ex_br_target = 32'd0;
    logic [31:0] ex_jalr_target = 32'd0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    br_resolve #(.BHT_IDX_W(6), .CTR_INIT(2'b01)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_pc_i         (id_pc),
        .id_pred_taken_o (id_pred_taken),
        .ex_valid_i      (ex_valid),
        .ex_stall_i      (ex_stall),
        .ex_is_br_i      (ex_is_br),
        .ex_is_jalr_i    (ex_is_jalr),
        .ex_pc_i         (ex_pc),
        .ex_pred_taken_i (ex_pred_taken),
        .br_en_i         (br_en),
        .ex_br_target_i  (ex_br_target),
        .ex_jalr_target_i(ex_jalr_target),
        .redirect_o      (redirect),
        .redirect_pc_o   (redirect_pc),
        .flush_o         (flush),
        .br_count_o      (br_count),
        .mispred_count_o (mispred_count)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Redirect monitor: every redirect must match the head of the queue in
    // both cycle and target; an expected redirect that never shows is a miss.
    always @(negedge clk) begin
        if (rst_n) begin
            if (redirect) begin
                n_checks++;
                if (sb.size() == 0 || sb[0].cyc != cyc) begin
                    $display("FAIL unexpected_redirect: redirect=1 at cycle %0d, none expected", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (redirect_pc === mon_e.pc && flush === 1'b1) n_pass++;
                    else $display("FAIL redirect_pc: got 0x%08h flush=%0b expected 0x%08h flush=1",
                                  redirect_pc, flush, mon_e.pc);
                end
            end else begin
                if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    n_checks++;
                    $display("FAIL missed_redirect: redirect=0 at cycle %0d expected 1 (pc 0x%08h)",
                             cyc, sb[0].pc);
                    void'(sb.pop_front());
                end
                if (flush !== 1'b0) begin
                    n_checks++;
                    $display("FAIL flush_idle: got %0b expected 0 at cycle %0d", flush, cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid   = 1'b0;
        ex_stall   = 1'b0;
        ex_is_br   = 1'b0;
        ex_is_jalr = 1'b0;
        br_en      = 1'b0;
        ex_pred_taken = 1'b0;
    endtask

    // Present a conditional branch; queue a redirect if it will mispredict.
    task automatic drive_br(input logic [31:0] pc, input logic pred,
                            input logic en, input logic [31:0] tgt);
        ex_valid      = 1'b1;
        ex_stall      = 1'b0;
        ex_is_br      = 1'b1;
        ex_is_jalr    = 1'b0;
        ex_pc         = pc;
        ex_pred_taken = pred;
        br_en         = en;
        ex_br_target  = tgt;
        if (pred != en) sb.push_back('{cyc: cyc + 1, pc: (en ? tgt : pc + 32'd4)});
    endtask

    task automatic br(input logic [31:0] pc, input logic pred,
                      input logic en, input logic [31:0] tgt);
        drive_br(pc, pred, en, tgt);
        step();
        idle();
    endtask

    initial begin
        // ---------------- reset state ----------------
        step(); step();
        rst_n = 1'b1;
        id_pc = 32'h100;
        #1;
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_br_count", br_count, 32'd0);
        chk("rst_mispred", mispred_count, 32'd0);
        chk("rst_pred", {31'd0, id_pred_taken}, 32'd0);
        step();

        // ---------------- training at pc 0x100 (entry 0) ----------------
        drive_br(32'h100, 1'b0, 1'b1, 32'h200);
        #1;
        chk("collision_pre_update", {31'd0, id_pred_taken}, 32'd0);
        step(); idle();
        chk("t1_pred", {31'd0, id_pred_taken}, 32'd1);      // 01 -> 10
        step();
        br(32'h100, 1'b0, 1'b1, 32'h200);                     // 10 -> 11
        step();
        br(32'h100, 1'b0, 1'b1, 32'h200);                     // 11 saturates
        chk("t3_mispred", mispred_count, 32'd3);
        chk("t3_br_count", br_count, 32'd3);
        chk("t3_pred", {31'd0, id_pred_taken}, 32'd1);
        step();
        br(32'h100, 1'b1, 1'b0, 32'h200);                     // 11 -> 10
        chk("t4_pred", {31'd0, id_pred_taken}, 32'd1);
        step();
        br(32'h100, 1'b1, 1'b0, 32'h200);                     // 10 -> 01
        chk("t5_pred", {31'd0, id_pred_taken}, 32'd0);
        chk("t5_redirect_pc", redirect_pc, 32'h104);
        step();
        br(32'h100, 1'b0, 1'b0, 32'h200);                     // 01 -> 00, correct
        step();
        br(32'h100, 1'b0, 1'b0, 32'h200);                     // 00 saturates
        chk("t7_br_count", br_count, 32'd7);
        chk("t7_mispred", mispred_count, 32'd5);
        step();
        br(32'h100, 1'b0, 1'b1, 32'h200);                     // 00 -> 01
        chk("t8_pred", {31'd0, id_pred_taken}, 32'd0);
        step();

        // ---------------- not-taken mispredict with PC wrap ----------------
        br(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h1234);
        chk("wrap_redirect_pc", redirect_pc, 32'h0);
        chk("wrap_br_count", br_count, 32'd9);
        chk("wrap_mispred", mispred_count, 32'd7);
        step();
        chk("wrap_redirect_drop", {31'd0, redirect}, 32'd0);

        // ---------------- ex_valid=0 has no effect ----------------
        ex_valid = 1'b0; ex_is_br = 1'b1; ex_pc = 32'h100;
        ex_pred_taken = 1'b1; br_en = 1'b0;
        step(); idle();
        chk("invalid_br_count", br_count, 32'd9);
        chk("invalid_mispred", mispred_count, 32'd7);
        step();

        // ---------------- shadow: second mispredict ignored ----------------
        drive_br(32'h340, 1'b0, 1'b1, 32'h400);
        step();
        ex_pc = 32'h344; ex_pred_taken = 1'b0; br_en = 1'b1; ex_br_target = 32'h500;
        step(); idle();
        chk("shadow_br_count", br_count, 32'd10);
        chk("shadow_mispred", mispred_count, 32'd8);
        id_pc = 32'h344; #1;
        chk("shadow_pred_b", {31'd0, id_pred_taken}, 32'd0);
        id_pc = 32'h340; #1;
        chk("shadow_pred_a", {31'd0, id_pred_taken}, 32'd1);
        chk("redirect_pc_hold", redirect_pc, 32'h400);
        step();

        // ---------------- stall: resolves once on release ----------------
        ex_valid = 1'b1; ex_stall = 1'b1; ex_is_br = 1'b1; ex_pc = 32'h580;
        ex_pred_taken = 1'b0; br_en = 1'b1; ex_br_target = 32'h600;
        step(); step(); step();
        chk("stall_br_count", br_count, 32'd10);
        chk("stall_mispred", mispred_count, 32'd8);
        ex_stall = 1'b0;
        sb.push_back('{cyc: cyc + 1, pc: 32'h600});
        step(); idle();
        chk("stall_rel_br_count", br_count, 32'd11);
        chk("stall_rel_mispred", mispred_count, 32'd9);
        id_pc = 32'h580; #1;
        chk("stall_pred", {31'd0, id_pred_taken}, 32'd1);
        step();

        // ---------------- JALR ----------------
        ex_valid = 1'b1; ex_is_jalr = 1'b1; ex_pc = 32'h700;
        ex_jalr_target = 32'h2000; ex_pred_taken = 1'b0; br_en = 1'b1;
        sb.push_back('{cyc: cyc + 1, pc: 32'h2000});
        step(); idle();
        chk("jalr_redirect_pc", redirect_pc, 32'h2000);
        chk("jalr_br_count", br_count, 32'd11);
        chk("jalr_mispred", mispred_count, 32'd9);
        step();
        // Both flags set: JALR wins, no BHT or counter update.
        ex_valid = 1'b1; ex_is_jalr = 1'b1; ex_is_br = 1'b1; ex_pc = 32'h7A0;
        ex_jalr_target = 32'h3000; ex_br_target = 32'h3333;
        ex_pred_taken = 1'b0; br_en = 1'b1;
        sb.push_back('{cyc: cyc + 1, pc: 32'h3000});
        step(); idle();
        chk("jalr_br_count2", br_count, 32'd11);
        chk("jalr_mispred2", mispred_count, 32'd9);
        id_pc = 32'h7A0; #1;
        chk("jalr_bht", {31'd0, id_pred_taken}, 32'd0);
        step(); step();

        // ---------------- asynchronous reset mid-redirect ----------------
        ex_valid = 1'b1; ex_is_br = 1'b1; ex_pc = 32'h804;
        ex_pred_taken = 1'b1; br_en = 1'b0;
        step(); idle();
        chk("pre_rst_redirect", {31'd0, redirect}, 32'd1);
        chk("pre_rst_redirect_pc", redirect_pc, 32'h808);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_redirect", {31'd0, redirect}, 32'd0);
        chk("async_rst_flush", {31'd0, flush}, 32'd0);
        chk("async_rst_redirect_pc", redirect_pc, 32'd0);
        chk("async_rst_br_count", br_count, 32'd0);
        chk("async_rst_mispred", mispred_count, 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) begin
            id_pc = i * 4;
            #1;
            chk($sformatf("bht_reset[%0d]", i), {31'd0, id_pred_taken}, 32'd0);
        end
        @(posedge clk); #1;
        // FSM must be back in RUN: the first branch after reset resolves.
        br(32'h100, 1'b0, 1'b1, 32'h200);
        chk("post_rst_br_count", br_count, 32'd1);
        chk("post_rst_mispred", mispred_count, 32'd1);
        step(); step();
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
